// File: rtl/uart_defs.sv
// Shared UART definitions for the RX block and the future TX block.
//   - 3-bit state encodings and the matching state enum
//   - 8N1 frame constants
//   - clks_per_bit(): baud divisor from clock frequency and line rate
package uart_defs;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StStart = ST_START,
    StData  = ST_DATA,
    StStop  = ST_STOP,
    StBreak = ST_BREAK
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tmr.sv
// Baud down-counter shared by the UART RX and TX blocks.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   load     - load load_val this cycle (has priority over counting)
//   load_val - value to load
//   expire   - high while the count is zero
// The count stops at zero, so expire stays high until the next load.
module uart_baud_tmr #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/uart_inst_rx.sv
// UART 8N1 receiver presenting each received byte as an instruction word.
// Ports:
//   clk       - system clock, all logic on the rising edge
//   rst_n     - asynchronous active-low reset
//   rx        - serial line, idle high, asynchronous to clk
//   inst_vld  - one-cycle pulse when a good frame completes
//   inst_wd   - last good byte, held until the next good frame
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   busy      - high whenever the receiver is not idle
module uart_inst_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       inst_vld,
  output logic [7:0] inst_wd,
  output logic       frame_err,
  output logic       busy
);

  import uart_defs::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_cpb_check
    $error("uart_inst_rx: CLKS_PER_BIT must be at least 8");
  end

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start edge.
  logic rx_meta, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_state_e state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  wd_q, wd_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expire;

  uart_baud_tmr #(
    .W (TW)
  ) u_baud_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      wd_q      <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      wd_q      <= wd_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    wd_d      = wd_q;
    vld_d     = 1'b0;
    ferr_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = FULL_LOAD;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          // First expiry lands mid start bit; later ones land mid each bit.
          state_d  = StStart;
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end
      end

      StStart: begin
        if (tmr_expire) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
            tmr_load  = 1'b1;
          end
        end
      end

      StData: begin
        if (tmr_expire) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          tmr_load  = 1'b1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = StStop;
          end
        end
      end

      StStop: begin
        if (tmr_expire) begin
          if (rx_s == STOP_LEVEL) begin
            wd_d    = shreg_q;
            vld_d   = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end

      // Held-low line: wait for it to return high so it yields a single frame_err.
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign inst_vld  = vld_q;
  assign inst_wd   = wd_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_inst_rx.sv
module tb_uart_inst_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx8;
  logic       inst_vld, frame_err, busy;
  logic [7:0] inst_wd;
  logic       inst_vld8, frame_err8, busy8;
  logic [7:0] inst_wd8;

  uart_inst_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .inst_vld  (inst_vld),
    .inst_wd   (inst_wd),
    .frame_err (frame_err),
    .busy      (busy)
  );

  uart_inst_rx #(
    .CLK_FREQ (100000000),
    .BAUD     (12500000)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx8),
    .inst_vld  (inst_vld8),
    .inst_wd   (inst_wd8),
    .frame_err (frame_err8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp8_q[$];

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ferr8_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: sample on the falling edge, pop the scoreboard on each pulse.
  always @(negedge clk) begin
    exp_t e;
    if (frame_err) ferr_cnt++;
    if (inst_vld) begin
      chk("vld_ferr_overlap", int'(frame_err), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("inst_wd", int'(inst_wd), int'(e.data));
        chk("vld_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (frame_err8) ferr8_cnt++;
    if (inst_vld8) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected_vld8", 1, 0);
      end else begin
        e = exp8_q.pop_front();
        chk("inst_wd8", int'(inst_wd8), int'(e.data));
        chk("vld8_latency", cyc, e.cyc);
      end
    end
  end

  task automatic drive_bit(input bit sel8, input logic v, input int n);
    if (sel8) rx8 = v;
    else rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the start edge is seen by the sync at the next rising edge.
  task automatic send_frame(input bit sel8, input logic [7:0] d, input logic stop,
                            input bit expect_ok);
    int   cpb = sel8 ? 8 : 100;
    int   lat = sel8 ? 79 : 953;
    exp_t e;
    if (expect_ok) begin
      e.data = d;
      e.cyc  = cyc + lat;
      if (sel8) exp8_q.push_back(e);
      else exp_q.push_back(e);
    end
    drive_bit(sel8, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(sel8, d[i], cpb);
    drive_bit(sel8, stop, cpb);
  endtask

  initial begin
    int g0;
    int f0;
    logic [7:0] ff_byte;

    rst_n = 1'b0;
    rx    = 1'b1;
    rx8   = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_vld", int'(inst_vld), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wd", int'(inst_wd), 8'h00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame
    send_frame(1'b0, 8'h1A, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_no_ferr", ferr_cnt, 0);

    // Back-to-back frames, no idle bit
    send_frame(1'b0, 8'h5B, 1'b1, 1'b1);
    send_frame(1'b0, 8'hE4, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // 30-cycle glitch
    f0 = ferr_cnt;
    g0 = cyc;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (21) @(negedge clk);
    chk("glitch_busy_high", int'(busy), 1);
    repeat (2) @(negedge clk);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_cycles", cyc - g0, 53);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    chk("glitch_wd_kept", int'(inst_wd), 8'hE4);
    repeat (20) @(negedge clk);

    // Stop bit low, line held low
    f0 = ferr_cnt;
    send_frame(1'b0, 8'h9C, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    chk("ferr_one_pulse", ferr_cnt - f0, 1);
    chk("ferr_wd_kept", int'(inst_wd), 8'hE4);
    chk("ferr_break_busy", int'(busy), 1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_busy_released", int'(busy), 0);
    send_frame(1'b0, 8'hC0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // Reset during bit 4 of 0xFF
    ff_byte = 8'hFF;
    drive_bit(1'b0, 1'b0, 100);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, ff_byte[i], 100);
    rx = ff_byte[4];
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", int'(inst_vld), 0);
    chk("midrst_ferr", int'(frame_err), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wd", int'(inst_wd), 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (97) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(1'b0, ff_byte[i], 100);
    drive_bit(1'b0, 1'b1, 100);
    repeat (20) @(negedge clk);
    chk("midrst_wd_after", int'(inst_wd), 8'h00);
    send_frame(1'b0, 8'h01, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // Minimum divisor instance
    send_frame(1'b1, 8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("cpb8_no_ferr", ferr8_cnt, 0);

    chk("pending_frames", exp_q.size(), 0);
    chk("pending_frames8", exp8_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
